// File: rtl/latch_pkg.sv
// Shared types and default parameters for the latch output debouncer.
// Also reused by the synchroniser for the future latch enable path.
package latch_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW   = 2'd0,
        CHECK_HIGH = 2'd1,
        IDLE_HIGH  = 2'd2,
        CHECK_LOW  = 2'd3
    } deb_state_t;

    localparam int SYNC_STAGES_DEF   = 2;
    localparam int STABLE_CYCLES_DEF = 4;
    localparam int GLITCH_W_DEF      = 8;

endpackage

// File: rtl/latch_sync.sv
// N-flop single-bit synchroniser with synchronous active-high reset.
module latch_sync #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [N-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else begin
            r_q <= {r_q[N-2:0], i_d};
        end
    end

    assign o_q = r_q[N-1];

endmodule

// File: rtl/latch_debounce.sv
// Synchronises and debounces the latch output into a clean level,
// with rise/fall strobes and a saturating rejected-glitch counter.
module latch_debounce
    import latch_pkg::*;
#(
    parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter int GLITCH_W      = GLITCH_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                l_out,
    input  logic                glitch_clr,
    output logic                level,
    output logic                rise,
    output logic                fall,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] STABLE_C = CW'(STABLE_CYCLES);
    localparam logic [GLITCH_W-1:0] G_MAX = {GLITCH_W{1'b1}};

    logic       w_s;
    deb_state_t r_state;
    deb_state_t w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [CW-1:0] w_cnt_inc;
    logic       w_level_nxt;
    logic       w_rise_nxt;
    logic       w_fall_nxt;
    logic       w_glitch;

    latch_sync #(
        .N(SYNC_STAGES)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .i_d(l_out),
        .o_q(w_s)
    );

    assign w_cnt_inc = r_cnt + CW'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_level_nxt = level;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        w_glitch    = 1'b0;
        case (r_state)
            IDLE_LOW: begin
                if (w_s) begin
                    w_state_nxt = CHECK_HIGH;
                    w_cnt_nxt   = CW'(1);
                end
            end
            CHECK_HIGH: begin
                if (!w_s) begin
                    w_state_nxt = IDLE_LOW;
                    w_cnt_nxt   = '0;
                    w_glitch    = 1'b1;
                end else if (w_cnt_inc == STABLE_C) begin
                    w_state_nxt = IDLE_HIGH;
                    w_cnt_nxt   = '0;
                    w_level_nxt = 1'b1;
                    w_rise_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            IDLE_HIGH: begin
                if (!w_s) begin
                    w_state_nxt = CHECK_LOW;
                    w_cnt_nxt   = CW'(1);
                end
            end
            CHECK_LOW: begin
                if (w_s) begin
                    w_state_nxt = IDLE_HIGH;
                    w_cnt_nxt   = '0;
                    w_glitch    = 1'b1;
                end else if (w_cnt_inc == STABLE_C) begin
                    w_state_nxt = IDLE_LOW;
                    w_cnt_nxt   = '0;
                    w_level_nxt = 1'b0;
                    w_fall_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = IDLE_LOW;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE_LOW;
            r_cnt   <= '0;
            level   <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            level   <= w_level_nxt;
            rise    <= w_rise_nxt;
            fall    <= w_fall_nxt;
        end
    end

    // Clear takes priority over a coincident glitch event.
    always_ff @(posedge clk) begin
        if (rst || glitch_clr) begin
            glitch_cnt <= '0;
        end else if (w_glitch && glitch_cnt != G_MAX) begin
            glitch_cnt <= glitch_cnt + GLITCH_W'(1);
        end
    end

endmodule

// File: tb/tb_latch_debounce.sv
// Bench for latch_debounce: directed scenarios plus random l_out runs,
// compared every cycle against a run-length reference model.
module tb_latch_debounce;

    localparam int SYNC   = 2;
    localparam int STABLE = 4;

    logic       clk;
    logic       rst;
    logic       l_out;
    logic       glitch_clr;
    logic       level_a, rise_a, fall_a;
    logic [7:0] gcnt_a;
    logic       level_b, rise_b, fall_b;
    logic [1:0] gcnt_b;

    int n_chk  = 0;
    int n_pass = 0;

    logic     m_q[$];
    logic     m_level, m_rise, m_fall;
    int       m_run;
    int       m_g8, m_g2;

    latch_debounce u_dut (
        .clk(clk), .rst(rst), .l_out(l_out),
        .glitch_clr(glitch_clr),
        .level(level_a), .rise(rise_a), .fall(fall_a),
        .glitch_cnt(gcnt_a)
    );

    latch_debounce #(.GLITCH_W(2)) u_sat (
        .clk(clk), .rst(rst), .l_out(l_out),
        .glitch_clr(glitch_clr),
        .level(level_b), .rise(rise_b), .fall(fall_b),
        .glitch_cnt(gcnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t",
                      tag, obs, exp, $time);
    endtask

    // Reference: s is l_out delayed SYNC edges; a run of s differing from
    // the committed level commits after STABLE cycles, else is a glitch.
    task automatic model_step();
        logic s;
        logic g;
        if (rst) begin
            m_q.delete();
            repeat (SYNC) m_q.push_back(1'b0);
            m_level = 0; m_rise = 0; m_fall = 0;
            m_run = 0; m_g8 = 0; m_g2 = 0;
        end else begin
            s = m_q.pop_front();
            m_q.push_back(l_out);
            g = 0; m_rise = 0; m_fall = 0;
            if (s != m_level) begin
                m_run++;
                if (m_run == STABLE) begin
                    m_level = s;
                    m_rise = s;
                    m_fall = !s;
                    m_run = 0;
                end
            end else if (m_run > 0) begin
                g = 1;
                m_run = 0;
            end
            if (glitch_clr) begin
                m_g8 = 0; m_g2 = 0;
            end else if (g) begin
                m_g8 = (m_g8 < 255) ? m_g8 + 1 : 255;
                m_g2 = (m_g2 < 3) ? m_g2 + 1 : 3;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("level", level_a, m_level);
        chk("rise", rise_a, m_rise);
        chk("fall", fall_a, m_fall);
        chk("gcnt", gcnt_a, m_g8);
        chk("level_w2", level_b, m_level);
        chk("gcnt_w2", gcnt_b, m_g2);
        chk("rise_and_fall", rise_a & fall_a, 0);
    endtask

    int nr, nf, rise_at;

    initial begin
        rst = 1; l_out = 1; glitch_clr = 0;
        // Reset held with l_out high
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rst_level", level_a, 0);
            chk("rst_rise", rise_a, 0);
            chk("rst_gcnt", gcnt_a, 0);
        end
        rst = 0; nr = 0; rise_at = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (rise_a) begin nr++; rise_at = i; end
        end
        chk("rel_rise_cnt", nr, 1);
        chk("rel_rise_at", rise_at, 6);

        // Clean fall then clean rise
        l_out = 0; nf = 0; rise_at = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (fall_a) begin nf++; rise_at = i; end
        end
        chk("clean_fall_cnt", nf, 1);
        chk("clean_fall_at", rise_at, 6);
        chk("clean_fall_lvl", level_a, 0);
        l_out = 1; nr = 0; rise_at = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (rise_a) begin nr++; rise_at = i; end
        end
        chk("clean_rise_cnt", nr, 1);
        chk("clean_rise_at", rise_at, 6);
        chk("clean_gcnt", gcnt_a, 0);
        l_out = 0;
        repeat (10) tick();

        // STABLE-1 pulse rejected, STABLE pulse accepted
        nr = 0;
        for (int i = 0; i < 12; i++) begin
            l_out = (i < 3);
            tick();
            if (rise_a) nr++;
        end
        chk("short_rise", nr, 0);
        chk("short_level", level_a, 0);
        chk("short_gcnt", gcnt_a, 1);
        nr = 0;
        for (int i = 0; i < 12; i++) begin
            l_out = (i < 4);
            tick();
            if (rise_a) nr++;
        end
        chk("exact_rise", nr, 1);
        chk("exact_gcnt", gcnt_a, 1);
        repeat (6) tick();

        // Glitch while high
        l_out = 1;
        repeat (10) tick();
        nf = 0;
        for (int i = 0; i < 10; i++) begin
            l_out = (i >= 2);
            tick();
            if (fall_a) nf++;
        end
        chk("hi_glitch_fall", nf, 0);
        chk("hi_glitch_lvl", level_a, 1);
        chk("hi_glitch_gcnt", gcnt_a, 2);
        l_out = 0;
        repeat (10) tick();

        // Saturation at width 2, then clear coincident with a glitch
        repeat (5) begin
            for (int i = 0; i < 10; i++) begin
                l_out = (i < 3);
                tick();
            end
        end
        chk("sat_gcnt_w2", gcnt_b, 3);
        chk("sat_gcnt_w8", gcnt_a, 7);
        for (int i = 0; i < 10; i++) begin
            l_out = (i < 3);
            glitch_clr = (i == 5);
            tick();
        end
        glitch_clr = 0;
        chk("clr_gcnt_w2", gcnt_b, 0);
        chk("clr_gcnt_w8", gcnt_a, 0);

        // Reset during CHECK_HIGH with cnt=2
        l_out = 1;
        repeat (4) tick();
        rst = 1;
        tick();
        chk("midrst_level", level_a, 0);
        chk("midrst_rise", rise_a, 0);
        chk("midrst_gcnt", gcnt_a, 0);
        rst = 0; l_out = 0; nr = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rise_a) nr++;
        end
        chk("midrst_norise", nr, 0);
        chk("midrst_gcnt2", gcnt_a, 0);

        // Random runs
        for (int k = 0; k < 600; k++) begin
            int len;
            len = $urandom_range(1, 7);
            l_out = ~l_out;
            for (int j = 0; j < len; j++) begin
                glitch_clr = ($urandom_range(0, 31) == 0);
                rst = ($urandom_range(0, 499) == 0);
                tick();
            end
        end
        rst = 0; glitch_clr = 0;
        repeat (10) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/latch_debounce.md
Name: latch_debounce

Overview:
- Downstream consumer of the level-sensitive latch output `l_out`.
- Synchronises `l_out` into the `clk` domain, then filters out pulses shorter than `STABLE_CYCLES`.
- Produces a clean level plus one-cycle rise and fall strobes.
- Counts rejected glitches in a saturating counter, so benches and later stages can check the latch's data and enable behaviour.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on `l_out`; legal values ≥2.
- STABLE_CYCLES, 4, consecutive synchronised cycles at the new value required before committing it; legal values ≥2.
- GLITCH_W, 8, width of the glitch counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- l_out  input  1  latch output; asynchronous to `clk`
- glitch_clr  input  1  synchronous clear of `glitch_cnt`
- level  output  1  debounced, committed value
- rise  output  1  one-cycle pulse when `level` commits 0→1
- fall  output  1  one-cycle pulse when `level` commits 1→0
- glitch_cnt  output  GLITCH_W  saturating count of rejected transitions

Behaviour:
- One clock; reset is synchronous and active-high. Ports are named `clk` and `rst`.
- Reset values:
  - all synchroniser flops = 0
  - state = IDLE_LOW
  - cnt = 0
  - level = 0, rise = 0, fall = 0
  - glitch_cnt = 0
- Reset mid-check: `rst` asserted in any state wins over all other events. It aborts a CHECK state with no glitch count and no strobe.
- Synchroniser:
  - `s` is the output of a SYNC_STAGES-deep flop chain sampling `l_out`.
  - The FSM uses only `s`, never `l_out` directly.
- Internal counter `cnt`: width $clog2(STABLE_CYCLES+1).
- FSM states: IDLE_LOW, CHECK_HIGH, IDLE_HIGH, CHECK_LOW.
  - IDLE_LOW:
    - s=1 → CHECK_HIGH, cnt←1.
    - s=0 → stay.
  - CHECK_HIGH, s=1:
    - If cnt+1 == STABLE_CYCLES → IDLE_HIGH, level←1, rise←1, cnt←0.
    - Otherwise cnt←cnt+1.
  - CHECK_HIGH, s=0 → IDLE_LOW, cnt←0, glitch event. `level` is unchanged.
  - IDLE_HIGH and CHECK_LOW mirror IDLE_LOW and CHECK_HIGH with polarity inverted. Commit sets level←0 and fall←1.
- Strobes:
  - `rise` and `fall` are registered and high for exactly one cycle, in the same cycle `level` first shows the new value.
  - `rise` and `fall` are never high together.
- Latency:
  - Take a clean `l_out` step, first sampled at edge E0.
  - `level` changes after edge E0 + SYNC_STAGES + STABLE_CYCLES − 1, i.e. on the 6th sampling edge with the defaults.
  - Total latency = SYNC_STAGES + STABLE_CYCLES cycles.
- Glitch rejection:
  - Any excursion of `s` lasting fewer than STABLE_CYCLES cycles is dropped.
  - Each aborted CHECK increments `glitch_cnt` by 1.
- Glitch counter:
  - Saturates at 2^GLITCH_W−1; no wrap.
  - `glitch_clr` zeroes it next cycle.
  - `glitch_clr` together with a glitch event in the same cycle → result is 0 (clear wins).
- Boundary: an excursion of exactly STABLE_CYCLES cycles is accepted.
- Stated property: a pulse of length STABLE_CYCLES−1 is rejected.
- No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- Package `latch_pkg`:
  - enum `deb_state_t` {IDLE_LOW, CHECK_HIGH, IDLE_HIGH, CHECK_LOW}
  - localparam default values for SYNC_STAGES and STABLE_CYCLES
- Sub-module `latch_sync`:
  - Parameterised N-flop bit synchroniser with synchronous active-high reset to 0.
  - Instantiated once; reusable for the latch `en` path later.

Test Plan:
- Reset: hold rst=1 with l_out=1 for 5 cycles → level=0, rise=0, fall=0, glitch_cnt=0 throughout. Release rst while l_out=1 → rise pulses once, 6 cycles later.
- Clean rise then fall: l_out 0→1 held 10 cycles, then 1→0 held 10 cycles → level=1 after 6 edges with a single rise pulse. level=0 6 edges after the fall step, with a single fall pulse. glitch_cnt=0.
- Glitch reject and boundary:
  - l_out high for 3 cycles then low → level stays 0, no rise, glitch_cnt=1.
  - l_out high for exactly 4 cycles → level=1, rise pulse, glitch_cnt unchanged.
- Glitch while high: with level=1, l_out low for 2 cycles → level stays 1, no fall, glitch_cnt increments.
- Saturation and clear (GLITCH_W=2): inject 5 glitches → glitch_cnt=3 (saturated). Assert glitch_clr in the same cycle as a 6th glitch event → glitch_cnt=0.
- Reset mid-check: assert rst during CHECK_HIGH at cnt=2 → next cycle state IDLE_LOW, level=0, no rise, glitch_cnt unchanged.
